// File: rtl/csr_reg.sv
// +--------------------------------------------------------------------------+
// | csr_reg : RV32I machine-mode CSR file with cycle/instret and trap state  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module csr_reg #(
  parameter logic [31:0] HART_ID  = 32'h0000_0000,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raddr_i,
  output logic [31:0] rdata_o,
  input  logic        instret_i,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        mret_i,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o,
  output logic        mie_global_o,
  output logic [31:0] mie_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        status_mie;
  logic        status_mpie;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [11:0] wa;
  logic [11:0] ra;
  logic        wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
  logic        wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth;
  logic        writable;
  logic [31:0] wmasked;
  logic [31:0] rd_state;

  // Only the low 12 address bits are decoded; the rest are intentionally ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, waddr_i[31:12], raddr_i[31:12], trap_pc_i[1:0]};

  assign wa = waddr_i[11:0];
  assign ra = raddr_i[11:0];

  assign wr_mstatus   = we_i && (wa == A_MSTATUS);
  assign wr_mie       = we_i && (wa == A_MIE);
  assign wr_mtvec     = we_i && (wa == A_MTVEC);
  assign wr_mscratch  = we_i && (wa == A_MSCRATCH);
  assign wr_mepc      = we_i && (wa == A_MEPC);
  assign wr_mcause    = we_i && (wa == A_MCAUSE);
  assign wr_mtval     = we_i && (wa == A_MTVAL);
  assign wr_mcycle    = we_i && (wa == A_MCYCLE);
  assign wr_mcycleh   = we_i && (wa == A_MCYCLEH);
  assign wr_minstret  = we_i && (wa == A_MINSTRET);
  assign wr_minstreth = we_i && (wa == A_MINSTRETH);

  assign writable = wr_mstatus | wr_mie | wr_mtvec | wr_mscratch | wr_mepc | wr_mcause |
                    wr_mtval | wr_mcycle | wr_mcycleh | wr_minstret | wr_minstreth;

  function automatic logic [31:0] mstatus_view(input logic mie_b, input logic mpie_b);
    return {19'b0, 2'b11, 3'b0, mpie_b, 3'b0, mie_b, 3'b0};
  endfunction

  always_comb begin
    wmasked = wdata_i;
    if (wr_mstatus) begin
      wmasked = mstatus_view(wdata_i[3], wdata_i[7]);
    end else if (wr_mtvec || wr_mepc) begin
      wmasked = {wdata_i[31:2], 2'b00};
    end
  end

  always_comb begin
    rd_state = 32'h0;
    case (ra)
      A_MSTATUS:             rd_state = mstatus_view(status_mie, status_mpie);
      A_MISA:                rd_state = MISA_VAL;
      A_MIE:                 rd_state = mie;
      A_MTVEC:               rd_state = mtvec;
      A_MSCRATCH:            rd_state = mscratch;
      A_MEPC:                rd_state = mepc;
      A_MCAUSE:              rd_state = mcause;
      A_MTVAL:               rd_state = mtval;
      A_MIP:                 rd_state = 32'h0;
      A_MCYCLE,   A_CYCLE:   rd_state = mcycle[31:0];
      A_MCYCLEH,  A_CYCLEH:  rd_state = mcycle[63:32];
      A_MINSTRET, A_INSTRET: rd_state = minstret[31:0];
      A_MINSTRETH, A_INSTRETH: rd_state = minstret[63:32];
      A_MHARTID:             rd_state = HART_ID;
      default:               rd_state = 32'h0;
    endcase
  end

  // Forwarding shows the value the write will store, not the counter's next increment.
  assign rdata_o = (writable && (ra == wa)) ? wmasked : rd_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_mie  <= 1'b0;
      status_mpie <= 1'b0;
      mepc        <= 32'h0;
      mcause      <= 32'h0;
    end else if (trap_i) begin
      status_mpie <= status_mie;
      status_mie  <= 1'b0;
      mepc        <= {trap_pc_i[31:2], 2'b00};
      mcause      <= trap_cause_i;
    end else begin
      if (mret_i) begin
        status_mie  <= status_mpie;
        status_mpie <= 1'b1;
      end else if (wr_mstatus) begin
        status_mie  <= wdata_i[3];
        status_mpie <= wdata_i[7];
      end
      if (wr_mepc)   mepc   <= {wdata_i[31:2], 2'b00};
      if (wr_mcause) mcause <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie      <= 32'h0;
      mtvec    <= 32'h0;
      mscratch <= 32'h0;
      mtval    <= 32'h0;
    end else begin
      if (wr_mie)      mie      <= wdata_i;
      if (wr_mtvec)    mtvec    <= {wdata_i[31:2], 2'b00};
      if (wr_mscratch) mscratch <= wdata_i;
      if (wr_mtval)    mtval    <= wdata_i;
    end
  end

  // A write to either half freezes the whole 64-bit counter for that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle <= 64'h0;
    end else if (wr_mcycle) begin
      mcycle[31:0] <= wdata_i;
    end else if (wr_mcycleh) begin
      mcycle[63:32] <= wdata_i;
    end else begin
      mcycle <= mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minstret <= 64'h0;
    end else if (wr_minstret) begin
      minstret[31:0] <= wdata_i;
    end else if (wr_minstreth) begin
      minstret[63:32] <= wdata_i;
    end else if (instret_i) begin
      minstret <= minstret + 64'd1;
    end
  end

  assign mtvec_o      = mtvec;
  assign mepc_o       = mepc;
  assign mie_global_o = status_mie;
  assign mie_o        = mie;

endmodule

`default_nettype wire

// File: tb/tb_csr_reg.sv
// Testbench for csr_reg: directed steps, expectations queued and checked against DUT outputs.
`timescale 1ns/1ps
`default_nettype none

module tb_csr_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] waddr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic [31:0] raddr_i = 32'h0;
  logic [31:0] rdata_o;
  logic        instret_i = 1'b0;
  logic        trap_i = 1'b0;
  logic [31:0] trap_pc_i = 32'h0;
  logic [31:0] trap_cause_i = 32'h0;
  logic        mret_i = 1'b0;
  logic [31:0] mtvec_o;
  logic [31:0] mepc_o;
  logic        mie_global_o;
  logic [31:0] mie_o;

  csr_reg #(.HART_ID(32'h0), .MISA_VAL(32'h4000_0100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .wdata_i      (wdata_i),
    .raddr_i      (raddr_i),
    .rdata_o      (rdata_o),
    .instret_i    (instret_i),
    .trap_i       (trap_i),
    .trap_pc_i    (trap_pc_i),
    .trap_cause_i (trap_cause_i),
    .mret_i       (mret_i),
    .mtvec_o      (mtvec_o),
    .mepc_o       (mepc_o),
    .mie_global_o (mie_global_o),
    .mie_o        (mie_o)
  );

  always #5 clk = ~clk;

  // src: 0 = rdata_o at addr, 1 = mtvec_o, 2 = mepc_o, 3 = mie_global_o, 4 = mie_o
  typedef struct {
    int          src;
    logic [31:0] addr;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic expect_rd(input logic [31:0] a, input logic [31:0] e, input string t);
    exp_t x;
    x.src = 0; x.addr = a; x.exp = e; x.tag = t;
    sb.push_back(x);
  endtask

  task automatic expect_port(input int s, input logic [31:0] e, input string t);
    exp_t x;
    x.src = s; x.addr = 32'h0; x.exp = e; x.tag = t;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t        x;
    logic [31:0] obs;
    while (sb.size() != 0) begin
      x = sb.pop_front();
      if (x.src == 0) raddr_i = x.addr;
      #0.1;
      case (x.src)
        0:       obs = rdata_o;
        1:       obs = mtvec_o;
        2:       obs = mepc_o;
        3:       obs = {31'b0, mie_global_o};
        default: obs = mie_o;
      endcase
      checks++;
      assert (obs === x.exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic idle();
    we_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0; instret_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    expect_rd(32'h300, 32'h0000_1800, "rst_mstatus");
    expect_rd(32'h301, 32'h4000_0100, "rst_misa");
    expect_rd(32'hF14, 32'h0, "rst_mhartid");
    expect_rd(32'hB00, 32'h0, "rst_mcycle");
    expect_port(1, 32'h0, "rst_mtvec_o");
    expect_port(2, 32'h0, "rst_mepc_o");
    expect_port(3, 32'h0, "rst_mie_global_o");
    expect_port(4, 32'h0, "rst_mie_o");
    drain();
    rst_n = 1'b1;

    @(negedge clk);
    expect_rd(32'hB00, 32'h1, "mcycle_first_edge");
    expect_rd(32'hC00, 32'h1, "cycle_shadow");
    expect_rd(32'h7C0, 32'h0, "unimpl_read");
    expect_rd(32'h344, 32'h0, "mip_zero");
    drain();

    // mtvec write with forwarding and alignment
    wr(32'h305, 32'h8000_0103);
    expect_rd(32'h305, 32'h8000_0100, "fwd_mtvec");
    expect_port(1, 32'h0, "mtvec_o_not_fwd");
    drain();
    @(negedge clk);
    idle();
    expect_port(1, 32'h8000_0100, "mtvec_o");
    expect_rd(32'h305, 32'h8000_0100, "rd_mtvec");
    drain();
    wr(32'h304, 32'hA5A5_0F0F);
    @(negedge clk);
    idle();
    expect_port(4, 32'hA5A5_0F0F, "mie_o");
    drain();

    // mcycle carry into high word
    wr(32'hB00, 32'hFFFF_FFFE);
    @(negedge clk);
    wr(32'hB80, 32'h0);
    @(negedge clk);
    idle();
    expect_rd(32'hB00, 32'hFFFF_FFFE, "mcycle_written");
    expect_rd(32'hB80, 32'h0, "mcycleh_written");
    drain();
    repeat (2) @(negedge clk);
    expect_rd(32'hB00, 32'h0, "mcycle_carry_lo");
    expect_rd(32'hB80, 32'h1, "mcycle_carry_hi");
    expect_rd(32'hC80, 32'h1, "cycleh_shadow");
    drain();
    wr(32'hC00, 32'h0000_1234);
    expect_rd(32'hC00, 32'h0, "ro_no_fwd");
    drain();
    @(negedge clk);
    idle();
    expect_rd(32'hC00, 32'h1, "ro_write_ignored");
    expect_rd(32'hB80, 32'h1, "mcycleh_kept");
    drain();

    // 64-bit wrap
    wr(32'hB00, 32'hFFFF_FFFF);
    @(negedge clk);
    wr(32'hB80, 32'hFFFF_FFFF);
    @(negedge clk);
    idle();
    expect_rd(32'hB00, 32'hFFFF_FFFF, "mcycle_max_lo");
    expect_rd(32'hB80, 32'hFFFF_FFFF, "mcycle_max_hi");
    drain();
    @(negedge clk);
    expect_rd(32'hB00, 32'h0, "mcycle_wrap_lo");
    expect_rd(32'hB80, 32'h0, "mcycle_wrap_hi");
    drain();

    // mstatus, trap entry, mret
    wr(32'h300, 32'h0000_0008);
    @(negedge clk);
    idle();
    expect_rd(32'h300, 32'h0000_1808, "mstatus_mie_set");
    expect_port(3, 32'h1, "mie_global_set");
    drain();
    trap_i = 1'b1; trap_pc_i = 32'h104; trap_cause_i = 32'h8000_0007;
    @(negedge clk);
    idle();
    expect_rd(32'h341, 32'h104, "trap_mepc");
    expect_rd(32'h342, 32'h8000_0007, "trap_mcause");
    expect_rd(32'h300, 32'h0000_1880, "trap_mstatus");
    expect_port(2, 32'h104, "trap_mepc_o");
    expect_port(3, 32'h0, "trap_mie_global");
    drain();
    mret_i = 1'b1;
    @(negedge clk);
    idle();
    expect_rd(32'h300, 32'h0000_1888, "mret_mstatus");
    expect_port(3, 32'h1, "mret_mie_global");
    drain();

    // trap priority over writes
    trap_i = 1'b1; trap_pc_i = 32'h300; trap_cause_i = 32'h2;
    wr(32'h341, 32'h200);
    @(negedge clk);
    idle();
    expect_rd(32'h341, 32'h300, "trap_beats_mepc_wr");
    expect_rd(32'h342, 32'h2, "trap_mcause2");
    drain();
    trap_i = 1'b1; trap_pc_i = 32'h402; trap_cause_i = 32'hB;
    wr(32'h340, 32'h55);
    @(negedge clk);
    idle();
    expect_rd(32'h340, 32'h55, "mscratch_wr_in_trap");
    expect_rd(32'h341, 32'h400, "trap_mepc_aligned");
    expect_rd(32'h300, 32'h0000_1800, "double_trap_mstatus");
    drain();

    // minstret with a write in the middle pulse
    instret_i = 1'b1;
    @(negedge clk);
    instret_i = 1'b1;
    wr(32'hB02, 32'd10);
    @(negedge clk);
    we_i = 1'b0;
    instret_i = 1'b1;
    @(negedge clk);
    idle();
    expect_rd(32'hB02, 32'd11, "minstret");
    expect_rd(32'hC02, 32'd11, "instret_shadow");
    expect_rd(32'hB82, 32'h0, "minstreth");
    drain();

    // asynchronous reset between clock edges
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    expect_port(1, 32'h0, "async_rst_mtvec_o");
    expect_port(4, 32'h0, "async_rst_mie_o");
    expect_rd(32'h340, 32'h0, "async_rst_mscratch");
    expect_rd(32'h300, 32'h0000_1800, "async_rst_mstatus");
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
